edge_evt_sched: RTL and testbench
=================================

Name: edge_evt_sched

Overview:
- Multi-channel edge-event controller and scheduler.
- Per channel: samples a level input, detects configurable rising/falling edges and queues one pending event.
- A round-robin arbiter serialises pending events onto a single valid/ready event port for a downstream consumer (interrupt logic or event logger).
- Sits between raw pad/strobe signals and the consumer; sequences and shares the edge-detect datapath among NCH requesters.

Parameters:
- NCH, 4, number of input channels (2..16).
- IDXW, 2, width of channel index; must equal ceil(log2(NCH)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- sig_in  input  NCH  level inputs, one bit per channel; synchronous to clk unless EDGE_SYNC_EN.
- cfg_mode  input  2*NCH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- evt_valid  output  1  event available.
- evt_ready  input  1  consumer accepts event when high with evt_valid.
- evt_ch  output  IDXW  channel index of presented event.
- evt_rise  output  1  1 = rising edge, 0 = falling edge.
- ovf  output  NCH  sticky per-channel overflow flags.
- ovf_clr  input  1  synchronous clear of all ovf bits.

Behaviour:
- Reset (rst=0, async):
  - evt_valid=0, evt_ch=0, evt_rise=0, ovf=0.
  - Pending flags=0, prev samples=0, armed=0.
  - RR pointer=NCH-1, so channel 0 wins first.
- Arming:
  - First clk after rst release loads prev<=sig_in and sets armed=1.
  - No edges are detected on that cycle, so a level high at reset release produces no event.
- Edge detect: edge[i] = armed & (sig_in[i] ^ prev[i]); prev<=sig_in every cycle.
- Enable: edge qualifies if mode 01 and sig_in[i]=1, mode 10 and sig_in[i]=0, or mode 11.
- Pending set:
  - Qualified edge sampled at clk edge k sets pend[i]=1 and pend_rise[i]=sig_in[i] at edge k.
  - The event can appear on evt_* after edge k+1 (1-cycle latency from pending to output).
- FSM states:
  - IDLE (evt_valid=0): if any pend, grant the first set bit searching from ptr+1 with wrap. Load evt_ch/evt_rise, clear that pend, set ptr=granted index, go to VALID.
  - VALID (evt_valid=1): evt_ch/evt_rise held stable until evt_ready=1.
  - On handshake with another pend set: load next grant the same cycle and stay VALID (1 event/cycle throughput).
  - On handshake with no pend: go to IDLE.
  - No handshake: stay VALID.
- Overflow:
  - Qualified edge on channel i while pend[i]=1 and i is not granted this cycle sets ovf[i]=1 and overwrites pend_rise[i] with the newest edge; the older event is lost.
- Simultaneous grant and edge on the same channel: pend cleared by grant, re-set by the new edge; no overflow.
- ovf_clr with a new overflow in the same cycle: set wins.
- Mode change to 00: new edges ignored; existing pend is kept and still delivered.
- Reset mid-operation: evt_valid drops immediately (async); the in-flight event and all pends are discarded.

Optional Feature:
- EDGE_SYNC_EN defined: each sig_in bit passes through a 2-flop synchroniser (reset to 0) before edge detect. Event latency increases by 2 cycles; arming waits until the synchroniser output is loaded (first 3 clks after release, no edges).
- EDGE_SYNC_EN undefined: sig_in is used directly; the caller guarantees synchronous inputs.

Decomposition:
- Package edge_evt_pkg holds:
  - mode constants MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11;
  - FSM state enum {ST_IDLE, ST_VALID}.
- Sub-module edge_det_ch, one per channel, generated NCH times: prev flop, qualification by mode, pend/pend_rise/ovf bits with clear-on-grant input.
- Top holds armed flag, RR arbiter, FSM and output register.

Test Plan:
- Reset release with sig_in=4'b1111, all modes 11 -> no evt_valid in the 5 cycles after release.
- Ch2 mode 01, sig_in[2] 0->1 -> evt_valid=1, evt_ch=2, evt_rise=1, 2 clks after the sampling edge; held until evt_ready=1, then evt_valid=0.
- Rising edges on ch0..ch3 in the same cycle, evt_ready=1 constant -> events in order ch 0,1,2,3 on 4 consecutive cycles.
- Repeat with last grant ch1 and new edges on ch0, ch3 -> order ch3, then ch0 (wrap).
- Ch1 mode 11, evt_ready=0 while ch1 toggles 0->1->0 (two edges, pend held behind a ch0 event) -> ovf[1]=1; delivered ch1 event has evt_rise=0. Then ovf_clr=1 for 1 clk -> ovf=0.
- Ch3 mode 10 with rising edge only -> no event. Assert rst=0 asynchronously while evt_valid=1 -> evt_valid=0 before next clk, ovf=0.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared constants, FSM state type and edge-qualification helper for edge_evt_sched.
package edge_evt_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic {ST_IDLE, ST_VALID} evt_state_e;

  // True when an edge ending at 'level' is enabled by 'mode'.
  function automatic logic edge_enabled(input logic [1:0] mode, input logic level);
    logic en;
    unique case (mode)
      MODE_OFF:  en = 1'b0;
      MODE_RISE: en = level;
      MODE_FALL: en = ~level;
      MODE_BOTH: en = 1'b1;
      default:   en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/edge_det_ch.sv
// One channel of edge detection: optional synchroniser, prev sample, mode qualification,
// single-deep pending event with sticky overflow. Optional feature macro: EDGE_SYNC_EN.
module edge_det_ch
  import edge_evt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       armed,
  input  logic       grant,
  input  logic       ovf_clr,
  output logic       pend,
  output logic       pend_rise,
  output logic       ovf
);

  logic lvl;

`ifdef EDGE_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], sig};
  end
  assign lvl = sync_q[1];
`else
  assign lvl = sig;
`endif

  logic prev_q, pend_q, rise_q, ovf_q;
  logic pend_d, rise_d, ovf_d;
  logic qual;

  assign qual = armed & (lvl ^ prev_q) & edge_enabled(mode, lvl);

  // A new edge on a channel being granted this cycle re-arms pend without overflow.
  always_comb begin
    pend_d = qual | (pend_q & ~grant);
    rise_d = qual ? lvl : rise_q;
    ovf_d  = (qual & pend_q & ~grant) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      rise_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= lvl;
      pend_q <= pend_d;
      rise_q <= rise_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend      = pend_q;
  assign pend_rise = rise_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/edge_evt_sched.sv
// Multi-channel edge-event scheduler: per-channel detectors, round-robin arbiter and a
// valid/ready event port. Optional feature macro: EDGE_SYNC_EN (2-flop input synchroniser).
module edge_evt_sched
  import edge_evt_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    sig_in,
  input  logic [2*NCH-1:0]  cfg_mode,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDXW-1:0]   evt_ch,
  output logic              evt_rise,
  output logic [NCH-1:0]    ovf,
  input  logic              ovf_clr
);

`ifdef EDGE_SYNC_EN
  localparam logic [1:0] ARM_CYC = 2'd3;
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
`endif

  logic [1:0]     arm_cnt_q;
  logic           armed;
  logic [NCH-1:0] pend, pend_rise, grant;

  // Edge detection stays off until the sample path holds real post-reset data.
  assign armed = (arm_cnt_q == ARM_CYC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        arm_cnt_q <= 2'd0;
    else if (!armed) arm_cnt_q <= arm_cnt_q + 2'd1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    edge_det_ch u_ch (
      .clk       (clk),
      .rst       (rst),
      .sig       (sig_in[i]),
      .mode      (cfg_mode[2*i +: 2]),
      .armed     (armed),
      .grant     (grant[i]),
      .ovf_clr   (ovf_clr),
      .pend      (pend[i]),
      .pend_rise (pend_rise[i]),
      .ovf       (ovf[i])
    );
  end

  // Round-robin: scan downwards so the nearest set bit after ptr_q wins.
  logic [IDXW-1:0] ptr_q, ptr_d, gnt_idx, cand_idx;
  logic            any_pend;
  int unsigned     cand;

  always_comb begin
    any_pend = |pend;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = NCH; k >= 1; k--) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NCH) cand = cand - NCH;
      cand_idx = IDXW'(cand);
      if (pend[cand_idx]) gnt_idx = cand_idx;
    end
  end

  evt_state_e      state_q, state_d;
  logic [IDXW-1:0] ch_q, ch_d;
  logic            rise_q, rise_d;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rise_d  = rise_q;
    ptr_d   = ptr_q;
    grant   = '0;
    if (state_q == ST_IDLE || evt_ready) begin
      state_d = ST_IDLE;
      if (any_pend) begin
        grant[gnt_idx] = 1'b1;
        ch_d           = gnt_idx;
        rise_d         = pend_rise[gnt_idx];
        ptr_d          = gnt_idx;
        state_d        = ST_VALID;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      rise_q  <= 1'b0;
      ptr_q   <= IDXW'(NCH - 1);
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rise_q  <= rise_d;
      ptr_q   <= ptr_d;
    end
  end

  assign evt_valid = (state_q == ST_VALID);
  assign evt_ch    = ch_q;
  assign evt_rise  = rise_q;

endmodule

// File: tb/tb_edge_evt_sched.sv
// Self-checking bench for edge_evt_sched: directed scenarios plus randomized traffic
// compared against an event-level reference model.
module tb_edge_evt_sched;

  localparam int NCH  = 4;
  localparam int IDXW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NCH-1:0]   sig_in = '0;
  logic [2*NCH-1:0] cfg_mode = '0;
  logic             evt_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             evt_valid;
  logic [IDXW-1:0]  evt_ch;
  logic             evt_rise;
  logic [NCH-1:0]   ovf;

  int vectors = 0;
  int errors  = 0;

  edge_evt_sched #(.NCH(NCH), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .cfg_mode  (cfg_mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel last level, one-deep mailbox, last-served channel.
  int             m_since;
  logic [NCH-1:0] m_prev, m_pend, m_prise, m_ovf;
  logic           m_valid, m_rise;
  int             m_ch, m_last;

  task automatic model_reset();
    m_since = 0; m_prev = '0; m_pend = '0; m_prise = '0; m_ovf = '0;
    m_valid = 1'b0; m_rise = 1'b0; m_ch = 0; m_last = NCH - 1;
  endtask

  task automatic model_clk();
    logic       live;
    logic [1:0] md;
    int         c;
    live = (m_since >= 1);
    if (!m_valid || evt_ready) begin
      m_valid = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
        c = (m_last + k) % NCH;
        if (m_pend[c]) begin
          m_valid = 1'b1; m_ch = c; m_rise = m_prise[c]; m_pend[c] = 1'b0; m_last = c;
          break;
        end
      end
    end
    if (ovf_clr) m_ovf = '0;
    for (int i = 0; i < NCH; i++) begin
      md = cfg_mode[2*i +: 2];
      if (live && sig_in[i] != m_prev[i] &&
          (md == 2'b11 || (md == 2'b01 && sig_in[i]) || (md == 2'b10 && !sig_in[i]))) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        m_pend[i]  = 1'b1;
        m_prise[i] = sig_in[i];
      end
    end
    m_prev = sig_in;
    if (m_since < 1) m_since++;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_clk();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b0; sig_in = 4'hF; cfg_mode = 8'hFF;
    #1;
    vectors++;
    if ({evt_valid, evt_ch, evt_rise, ovf} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got v=%b ch=%0d r=%b ovf=%b want all zero",
               evt_valid, evt_ch, evt_rise, ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      vectors++;
      if (evt_valid !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL arm_no_event cyc%0d: got valid=%b want 0", n, evt_valid);
      end
    end
    cfg_mode = 8'h00; sig_in = 4'h0;
    step();
  endtask

  task automatic test_back_to_back();
    cfg_mode = 8'h55; evt_ready = 1'b1; sig_in = 4'hF;
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_latency: got valid=%b want 0", evt_valid);
    end
    for (int k = 0; k < NCH; k++) begin
      step();
      vectors++;
      if (evt_valid !== 1'b1 || evt_ch !== k[IDXW-1:0] || evt_rise !== 1'b1) begin
        errors++;
        $display("FAIL b2b_order: got v=%b ch=%0d r=%b want v=1 ch=%0d r=1",
                 evt_valid, evt_ch, evt_rise, k);
      end
    end
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_wrap();
    sig_in = 4'h0; step();
    sig_in = 4'b0010; step();
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin
      errors++; $display("FAIL wrap_setup: got v=%b ch=%0d want v=1 ch=1", evt_valid, evt_ch);
    end
    step();
    sig_in = 4'b1011; step();
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd3) begin
      errors++; $display("FAIL wrap_first: got v=%b ch=%0d want v=1 ch=3", evt_valid, evt_ch);
    end
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
      errors++; $display("FAIL wrap_second: got v=%b ch=%0d want v=1 ch=0", evt_valid, evt_ch);
    end
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_drain: got valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_single();
    cfg_mode = 8'h10; evt_ready = 1'b0; sig_in = 4'h0;
    step();
    sig_in = 4'b0100;
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: got valid=%b want 0", evt_valid);
    end
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_rise !== 1'b1) begin
      errors++;
      $display("FAIL single_event: got v=%b ch=%0d r=%b want v=1 ch=2 r=1",
               evt_valid, evt_ch, evt_rise);
    end
    for (int n = 0; n < 3; n++) begin
      step();
      vectors++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_rise !== 1'b1) begin
        errors++;
        $display("FAIL single_hold: got v=%b ch=%0d r=%b want v=1 ch=2 r=1",
                 evt_valid, evt_ch, evt_rise);
      end
    end
    evt_ready = 1'b1;
    step();
    vectors++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL single_accept: got valid=%b want 0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    cfg_mode = 8'h0D; sig_in = 4'h0; step();
    sig_in = 4'b0001; step();
    step();
    sig_in = 4'b0011; step();
    sig_in = 4'b0001; step();
    vectors++;
    if (ovf !== 4'b0010 || evt_valid !== 1'b1 || evt_ch !== 2'd0) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b v=%b ch=%0d want ovf=0010 v=1 ch=0",
               ovf, evt_valid, evt_ch);
    end
    evt_ready = 1'b1;
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_rise !== 1'b0) begin
      errors++;
      $display("FAIL ovf_newest: got v=%b ch=%0d r=%b want v=1 ch=1 r=0",
               evt_valid, evt_ch, evt_rise);
    end
    step();
    evt_ready = 1'b0; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++;
    if (ovf !== 4'b0000) begin
      errors++; $display("FAIL ovf_clear: got ovf=%b want 0000", ovf);
    end
  endtask

  task automatic test_mode_off();
    cfg_mode = 8'h80; sig_in = 4'b1001;
    for (int n = 0; n < 3; n++) begin
      step();
      vectors++;
      if (evt_valid !== 1'b0) begin
        errors++; $display("FAIL fall_only_rise: got valid=%b want 0", evt_valid);
      end
    end
    sig_in = 4'b0001;
    step();
    cfg_mode = 8'h00;
    step();
    vectors++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || evt_rise !== 1'b0) begin
      errors++;
      $display("FAIL mode_off_keeps_pend: got v=%b ch=%0d r=%b want v=1 ch=3 r=0",
               evt_valid, evt_ch, evt_rise);
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (n % 32 == 0) cfg_mode = 8'($urandom);
      sig_in    = sig_in ^ (4'($urandom) & 4'($urandom));
      evt_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      step();
      vectors++;
      if (evt_valid !== m_valid || ovf !== m_ovf ||
          (m_valid && (evt_ch !== m_ch[IDXW-1:0] || evt_rise !== m_rise))) begin
        errors++;
        $display("FAIL random cyc%0d: got v=%b ch=%0d r=%b ovf=%b want v=%b ch=%0d r=%b ovf=%b",
                 n, evt_valid, evt_ch, evt_rise, ovf, m_valid, m_ch, m_rise, m_ovf);
      end
    end
    ovf_clr = 1'b0; cfg_mode = 8'h00; evt_ready = 1'b1;
    repeat (NCH + 2) step();
    evt_ready = 1'b0;
    vectors++;
    if (evt_valid !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL random_drain: got valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_async_reset();
    sig_in = 4'h0; step();
    cfg_mode = 8'h03;
    sig_in = 4'b0001; step();
    step();
    sig_in = 4'b0000; step();
    sig_in = 4'b0001; step();
    vectors++;
    if (ovf[0] !== 1'b1 || evt_valid !== 1'b1 || evt_ch !== 2'd0 || ovf !== m_ovf) begin
      errors++;
      $display("FAIL pre_reset: got ovf=%b v=%b ch=%0d want ovf=%b v=1 ch=0",
               ovf, evt_valid, evt_ch, m_ovf);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (evt_valid !== 1'b0 || ovf !== 4'b0000 || evt_ch !== 2'd0 || evt_rise !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b ovf=%b ch=%0d r=%b want all zero",
               evt_valid, ovf, evt_ch, evt_rise);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_single();
    test_overflow();
    test_mode_off();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
